ce_divider_bank: RTL and testbench
==================================

# ce_divider_bank

Multi-channel programmable clock-enable generator for the single `clk_sys` domain. It replaces the fixed-ratio pixel counter in the core top level with CHANNELS independent dividers. Typical channels are pixel CE, CPU CE (1/2/4/8/10 MHz overclock steps) and UART baud CE. Each channel takes a new divisor without glitching, has a mid-period (`ce_half`) strobe, and can optionally add fractional stretch for non-integer ratios.

## Interface
- `CHANNELS`, default 2: number of independent divider channels.
- `DIV_W`, default 8: divisor width. Period is `div+1` clocks.
- `FRAC_W`, default 8: fractional accumulator width. Used only with `CE_FRAC_EN`.
- `DEFAULT_DIV`, default 5: active divisor for every channel after reset.
- `clk`  in  1: system clock, `clk_sys`.
- `n_reset`  in  1: asynchronous active-low reset.
- `enable`  in  CHANNELS: per-channel run. Low holds the channel stopped.
- `div`  in  CHANNELS*DIV_W: requested divisor. Channel i occupies bits `[i*DIV_W +: DIV_W]`.
- `load`  in  CHANNELS: single-cycle request to adopt `div` for channel i.
- `frac`  in  CHANNELS*FRAC_W: fractional increment per period. Ignored without `CE_FRAC_EN`.
- `ce`  out  CHANNELS: registered one-clock enable strobe at each period end.
- `ce_half`  out  CHANNELS: registered strobe at mid-period.
- `pending`  out  CHANNELS: a loaded divisor is waiting for the period boundary.

## Operation
Per-channel state:
- `cnt`: DIV_W+1 bits.
- `act_div`: DIV_W bits.
- `pend_div`: DIV_W bits.
- `pend_flag`: 1 bit.
- `stretch`: 1 bit.
- `acc`: FRAC_W bits.

Effective target `tgt = act_div + stretch`, computed at DIV_W+1 bits with no overflow.

Running (`enable` = 1), on each edge:
- **If `cnt == tgt` (terminal):** `cnt` ← 0 and `ce` ← 1.
  - If `load` is asserted on this edge, `act_div` ← `div` and `pend_flag` ← 0. `load` wins over an older pending value.
  - Otherwise, if `pend_flag` is set, `act_div` ← `pend_div` and `pend_flag` ← 0.
  - With `CE_FRAC_EN`, `{carry, acc}` ← `acc + frac`, then `stretch` ← `carry`.
- **Otherwise:** `cnt` ← `cnt + 1` and `ce` ← 0.
  - If `load` is asserted, `pend_div` ← `div` and `pend_flag` ← 1. A repeated load overwrites `pend_div`.
- **`ce_half`:** ← 1 when `act_div` ≥ 1 and `cnt + 1 == (act_div+1) >> 1` (integer division). Otherwise ← 0.
- **`act_div == 0`** (and `stretch == 0`): `ce` is high every cycle and `ce_half` stays low.

Stopped (`enable` = 0), on each edge:
- `cnt` ← 0, `ce` ← 0, `ce_half` ← 0, `stretch` ← 0, `acc` ← 0.
- A `load` or `pend_flag` is applied to `act_div` immediately, because no period is in flight. `pend_flag` ← 0.

General rules:
- `pending` = `pend_flag`.
- Channels share no state and are fully independent.
- No period is ever shortened by a divisor change: the old period always completes.

## Timing
- Reset state of every output: `ce`, `ce_half` and `pending` are all 0.
- Reset state of internal registers: `cnt` = 0, `act_div` = `DEFAULT_DIV`, `acc` = 0, `stretch` = 0.
- Reset applies asynchronously, mid-period included.
- First `ce` after reset release (or after `enable` rises): high in the cycle after edge number `act_div+1`. Strobes then repeat every `act_div+1+stretch` clocks.
- `ce` and `ce_half` come directly from flops, with no combinational path from the inputs.
- `load`-to-effect latency:
  - Running: at the next terminal edge.
  - Stopped: 1 edge.
- `pending` rises 1 cycle after a non-terminal `load` and falls on the terminal edge.

## Configuration
- **`CE_FRAC_EN` defined:** `acc` and `stretch` are synthesised.
  - Average period = `div + 1 + frac / 2^FRAC_W` clocks.
  - Stretched periods are exactly one clock longer.
- **`CE_FRAC_EN` undefined:** `acc` and `stretch` are not synthesised.
  - `stretch` is constant 0 and `frac` is ignored.
  - The `frac` port stays in the port list, so instantiations need no change.

## Test plan
- **Reset default:** `DEFAULT_DIV`=5, `enable`=1 → `ce` first high in cycle 6 after reset release, then every 6 clocks. `ce_half` is high 3 clocks after each `ce`.
- **Mid-period load:** `load` with `div`=11 at `cnt`=2 → `pending`=1, the current period still ends at 6 clocks, and subsequent periods are 12 clocks. No short pulse occurs.
- **Simultaneous load and terminal:** `load` with `div`=3 on the terminal edge → the next period is 4 clocks and `pending` never asserts.
- **Zero divisor:** `div`=0 → `ce` is constantly 1 and `ce_half` is constantly 0.
- **Enable toggle and reset:**
  - Drop `enable` mid-period → `ce` is 0 the next cycle.
  - Raise `enable` → first `ce` after `act_div+1` edges.
  - Assert `n_reset`=0 mid-period → all outputs 0 immediately and `act_div` returns to 5.
- **Fractional stretch (`CE_FRAC_EN`, two channels):**
  - ch0: `div`=5, `frac`=0x80, `FRAC_W`=8 → periods alternate 6 and 7; 256 strobes span 1664 clocks.
  - ch1: `div`=47 → unaffected, one strobe per 48 clocks.

Source files
------------

// File: rtl/ce_divider_bank.sv
// Bank of independent programmable clock-enable dividers with glitch-free divisor updates.
// Define CE_FRAC_EN to add per-channel fractional period stretching.
module ce_divider_bank #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned FRAC_W      = 8,
  parameter int unsigned DEFAULT_DIV = 5
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic [CHANNELS-1:0]        enable,
  input  logic [CHANNELS*DIV_W-1:0]  div,
  input  logic [CHANNELS-1:0]        load,
  input  logic [CHANNELS*FRAC_W-1:0] frac,
  output logic [CHANNELS-1:0]        ce,
  output logic [CHANNELS-1:0]        ce_half,
  output logic [CHANNELS-1:0]        pending
);

`ifndef CE_FRAC_EN
  // frac stays in the port list so instantiations are build-independent
  logic unused_frac;
  assign unused_frac = ^frac;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DIV_W:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0] act_div_q, act_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_q, pend_d;
    logic             ce_q, ce_d;
    logic             half_q, half_d;
    logic             stretch;
    logic [DIV_W-1:0] div_ch;
    logic [DIV_W:0]   tgt;
    logic [DIV_W:0]   cnt_inc;
    logic [DIV_W:0]   half_pt;
    logic             terminal;

    assign div_ch   = div[i*DIV_W +: DIV_W];
    assign tgt      = {1'b0, act_div_q} + {{DIV_W{1'b0}}, stretch};
    assign cnt_inc  = cnt_q + (DIV_W+1)'(1);
    assign half_pt  = ({1'b0, act_div_q} + (DIV_W+1)'(1)) >> 1;
    assign terminal = (cnt_q == tgt);

    always_comb begin
      cnt_d      = cnt_q;
      act_div_d  = act_div_q;
      pend_div_d = pend_div_q;
      pend_d     = pend_q;
      ce_d       = 1'b0;
      half_d     = 1'b0;
      if (!enable[i]) begin
        // No period in flight, so any new divisor takes effect at once
        cnt_d = '0;
        if (load[i]) begin
          act_div_d = div_ch;
        end else if (pend_q) begin
          act_div_d = pend_div_q;
        end
        pend_d = 1'b0;
      end else begin
        half_d = (act_div_q != '0) && (cnt_inc == half_pt);
        if (terminal) begin
          cnt_d = '0;
          ce_d  = 1'b1;
          if (load[i]) begin
            act_div_d = div_ch;
          end else if (pend_q) begin
            act_div_d = pend_div_q;
          end
          pend_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          if (load[i]) begin
            pend_div_d = div_ch;
            pend_d     = 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
        cnt_q      <= '0;
        act_div_q  <= DIV_W'(DEFAULT_DIV);
        pend_div_q <= '0;
        pend_q     <= 1'b0;
        ce_q       <= 1'b0;
        half_q     <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        act_div_q  <= act_div_d;
        pend_div_q <= pend_div_d;
        pend_q     <= pend_d;
        ce_q       <= ce_d;
        half_q     <= half_d;
      end
    end

`ifdef CE_FRAC_EN
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              stretch_q, stretch_d;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc_q} + {1'b0, frac[i*FRAC_W +: FRAC_W]};

    // Carry out of the accumulator lengthens the next period by one clock
    always_comb begin
      acc_d     = acc_q;
      stretch_d = stretch_q;
      if (!enable[i]) begin
        acc_d     = '0;
        stretch_d = 1'b0;
      end else if (terminal) begin
        acc_d     = acc_sum[FRAC_W-1:0];
        stretch_d = acc_sum[FRAC_W];
      end
    end

    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
        acc_q     <= '0;
        stretch_q <= 1'b0;
      end else begin
        acc_q     <= acc_d;
        stretch_q <= stretch_d;
      end
    end

    assign stretch = stretch_q;
`else
    assign stretch = 1'b0;
`endif

    assign ce[i]      = ce_q;
    assign ce_half[i] = half_q;
    assign pending[i] = pend_q;
  end

endmodule

// File: tb/tb_ce_divider_bank.sv
// Self-checking bench for ce_divider_bank: period-level model plus directed literal checks.
module tb_ce_divider_bank;
  localparam int unsigned CH = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned FW = 8;

  logic             clk = 1'b0;
  logic             n_reset;
  logic [CH-1:0]    enable;
  logic [CH-1:0]    load;
  logic [CH*DW-1:0] div;
  logic [CH*FW-1:0] frac;
  logic [CH-1:0]    ce;
  logic [CH-1:0]    ce_half;
  logic [CH-1:0]    pending;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ce_divider_bank #(
    .CHANNELS   (CH),
    .DIV_W      (DW),
    .FRAC_W     (FW),
    .DEFAULT_DIV(5)
  ) dut (
    .clk    (clk),
    .n_reset(n_reset),
    .enable (enable),
    .div    (div),
    .load   (load),
    .frac   (frac),
    .ce     (ce),
    .ce_half(ce_half),
    .pending(pending)
  );

  // Model: each channel tracks its position within the current period and that period's length
  int m_act[CH];
  int m_pdiv[CH];
  int m_phase[CH];
  int m_stretch[CH];
  int m_acc[CH];
  bit m_pend[CH];
  bit m_ce[CH];
  bit m_half[CH];

  always @(posedge clk or negedge n_reset) begin : model
    int d;
    int len;
    if (!n_reset) begin
      for (int i = 0; i < CH; i++) begin
        m_act[i] = 5; m_pdiv[i] = 0; m_phase[i] = 0; m_stretch[i] = 0; m_acc[i] = 0;
        m_pend[i] = 0; m_ce[i] = 0; m_half[i] = 0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        d = int'(div[i*DW +: DW]);
        if (!enable[i]) begin
          if (load[i]) m_act[i] = d;
          else if (m_pend[i]) m_act[i] = m_pdiv[i];
          m_pend[i] = 0; m_phase[i] = 0; m_ce[i] = 0; m_half[i] = 0;
          m_stretch[i] = 0; m_acc[i] = 0;
        end else begin
          len = m_act[i] + 1 + m_stretch[i];
          m_half[i] = (m_act[i] >= 1) && (m_phase[i] + 1 == (m_act[i] + 1) / 2);
          if (m_phase[i] == len - 1) begin
            m_ce[i] = 1;
            m_phase[i] = 0;
            if (load[i]) m_act[i] = d;
            else if (m_pend[i]) m_act[i] = m_pdiv[i];
            m_pend[i] = 0;
`ifdef CE_FRAC_EN
            m_acc[i] = m_acc[i] + int'(frac[i*FW +: FW]);
            m_stretch[i] = m_acc[i] / (1 << FW);
            m_acc[i] = m_acc[i] % (1 << FW);
`endif
          end else begin
            m_ce[i] = 0;
            m_phase[i] = m_phase[i] + 1;
            if (load[i]) begin
              m_pdiv[i] = d;
              m_pend[i] = 1;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample on the falling edge and compare every channel against the model
  task automatic cyc();
    @(negedge clk);
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("model ce[%0d]", i), int'(ce[i]), int'(m_ce[i]));
      chk($sformatf("model ce_half[%0d]", i), int'(ce_half[i]), int'(m_half[i]));
      chk($sformatf("model pending[%0d]", i), int'(pending[i]), int'(m_pend[i]));
    end
  endtask

  task automatic run_until(input int ch, input bit half, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (((half ? ce_half[ch] : ce[ch]) !== 1'b1) && n < 400);
  endtask

  task automatic set_div(input int ch, input int v);
    div[ch*DW +: DW] = DW'(v);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int n;
    int total;
    n_reset = 1'b1;
    enable  = '1;
    load    = '0;
    div     = '0;
`ifdef CE_FRAC_EN
    frac    = '0;
`else
    frac    = 16'hc0c0;
`endif
    #1 n_reset = 1'b0;
    #2;
    chk("reset ce", int'(ce), 0);
    chk("reset ce_half", int'(ce_half), 0);
    chk("reset pending", int'(pending), 0);
    cyc();
    n_reset = 1'b1;

    // Default divisor 5: ce every 6 clocks, ce_half 3 clocks after ce
    run_until(0, 1'b0, n); chk("first ce after reset", n, 6);
    run_until(0, 1'b1, n); chk("ce_half after ce", n, 3);
    run_until(0, 1'b0, n); chk("ce after ce_half", n, 3);

    // Mid-period load at cnt=2
    cyc(); cyc();
    set_div(0, 11); load[0] = 1'b1;
    cyc();
    load[0] = 1'b0;
    chk("pending after mid load", int'(pending[0]), 1);
    run_until(0, 1'b0, n); chk("old period completes", n, 3);
    chk("pending cleared at terminal", int'(pending[0]), 0);
    run_until(0, 1'b0, n); chk("new period 12", n, 12);

    // Load on the terminal edge
    repeat (11) cyc();
    set_div(0, 3); load[0] = 1'b1;
    cyc();
    load[0] = 1'b0;
    chk("ce on terminal load", int'(ce[0]), 1);
    chk("no pending on terminal load", int'(pending[0]), 0);
    run_until(0, 1'b0, n); chk("period 4 after terminal load", n, 4);

    // Zero divisor
    repeat (3) cyc();
    set_div(0, 0); load[0] = 1'b1;
    cyc();
    load[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("zero div ce", int'(ce[0]), 1);
      chk("zero div ce_half", int'(ce_half[0]), 0);
    end

    // Enable drop and stopped load
    enable[0] = 1'b0;
    cyc();
    chk("ce low after enable drop", int'(ce[0]), 0);
    set_div(0, 2); load[0] = 1'b1;
    cyc();
    load[0] = 1'b0;
    chk("no pending when stopped", int'(pending[0]), 0);
    cyc();
    enable[0] = 1'b1;
    run_until(0, 1'b0, n); chk("first ce after enable, div 2", n, 3);

    // Async reset mid-cycle with ce high on ch0 and pending on ch1
    enable[0] = 1'b0; set_div(0, 0); load[0] = 1'b1;
    cyc();
    load[0] = 1'b0; enable[0] = 1'b1;
    run_until(1, 1'b0, n);
    cyc();
    set_div(1, 20); load[1] = 1'b1;
    cyc();
    load[1] = 1'b0;
    chk("ch0 ce high before reset", int'(ce[0]), 1);
    chk("ch1 pending before reset", int'(pending[1]), 1);
    #2 n_reset = 1'b0;
    #1;
    chk("async reset ce", int'(ce), 0);
    chk("async reset ce_half", int'(ce_half), 0);
    chk("async reset pending", int'(pending), 0);
    cyc();
    n_reset = 1'b1;
    run_until(0, 1'b0, n); chk("act_div back to 5 after reset", n, 6);

`ifdef CE_FRAC_EN
    // ch0 div 5 + 0x80/256, ch1 div 47 integer
    enable = '0;
    set_div(0, 5); set_div(1, 47);
    frac = {8'h00, 8'h80};
    load = '1;
    cyc();
    load = '0; enable = '1;
    run_until(0, 1'b0, n); chk("frac period 1", n, 6);
    run_until(0, 1'b0, n); chk("frac period 2", n, 6);
    run_until(0, 1'b0, n); chk("frac period 3 stretched", n, 7);
    total = 0;
    for (int k = 0; k < 256; k++) begin
      run_until(0, 1'b0, n);
      total += n;
    end
    chk("256 frac periods", total, 1664);
    run_until(1, 1'b0, n);
    run_until(1, 1'b0, n); chk("ch1 integer period", n, 48);
`else
    total = 0;
    for (int k = 0; k < 4; k++) begin
      run_until(0, 1'b0, n);
      total += n;
    end
    chk("frac ignored, 4 periods", total, 24);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
